// File: rtl/data_mem.sv
// Word-organised data memory: asynchronous load, rising-edge store, async clear on rst.
// Optional DMEM_BOUNDS_CHECK_EN adds addrErr and blocks accesses whose high address bits are set.
module data_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              memRead,
    input  logic              memWrite,
    output logic [DATA_W-1:0] readData
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic              addrErr
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0]  idx;
    logic              addr_ok;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    assign idx = address[IDX_W+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    logic hi_nz;
    logic unused_lo;

    assign hi_nz     = |address[ADDR_W-1:IDX_W+2];
    assign addr_ok   = ~hi_nz;
    assign addrErr   = ~rst & (memRead | memWrite) & hi_nz;
    assign unused_lo = ^address[1:0];
`else
    // High bits wrap the address space; byte-offset bits never select anything.
    logic unused_bits;

    assign addr_ok     = 1'b1;
    assign unused_bits = ^{address[ADDR_W-1:IDX_W+2], address[1:0]};
`endif

    // An unknown idx makes the indexed write a no-op, so X addresses cannot hit other words.
    always_comb begin
        mem_d = mem_q;
        if (memWrite && addr_ok) begin
            mem_d[idx] = writeData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        readData = '0;
        if (!rst && memRead && addr_ok) begin
            readData = mem_q[idx];
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: reset clear, store/load, alignment, gating, same-cycle R/W, wrap/bounds.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] readData;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic        addrErr;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .writeData (writeData),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .readData  (readData)
`ifdef DMEM_BOUNDS_CHECK_EN
        ,
        .addrErr   (addrErr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memRead   = 1'b0;
        memWrite  = 1'b1;
        address   = a;
        writeData = d;
        @(posedge clk);
        #1;
        memWrite  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memWrite = 1'b0;
        memRead  = 1'b1;
        address  = a;
        #1;
        chk(tag, readData, exp);
    endtask

    initial begin
        rst       = 1'b1;
        address   = 32'h0;
        writeData = 32'h0;
        memRead   = 1'b1;
        memWrite  = 1'b0;
        #1;
        chk("reset_rdata", readData, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("post_reset_zero", 32'h0, 32'h0);

        // store then load, no clock edge between address change and check
        wr(32'h8, 32'h1234_5678);
        rd_chk("store_load", 32'h8, 32'h1234_5678);

        wr(32'h4, 32'hCAFE_F00D);
        rd_chk("align_5", 32'h5, 32'hCAFE_F00D);
        rd_chk("align_6", 32'h6, 32'hCAFE_F00D);
        rd_chk("align_7", 32'h7, 32'hCAFE_F00D);
        rd_chk("neighbor_8", 32'h8, 32'h1234_5678);

        memRead = 1'b0;
        address = 32'h8;
        #1;
        chk("rd_gate", readData, 32'h0);

        @(negedge clk);
        memWrite  = 1'b0;
        writeData = 32'hFFFF_FFFF;
        address   = 32'h8;
        @(posedge clk);
        #1;
        rd_chk("no_write", 32'h8, 32'h1234_5678);

        // same-cycle read and write at one index
        wr(32'h20, 32'h1);
        @(negedge clk);
        address   = 32'h20;
        memRead   = 1'b1;
        memWrite  = 1'b1;
        writeData = 32'h2;
        #1;
        chk("rw_before", readData, 32'h1);
        @(posedge clk);
        #1;
        chk("rw_after", readData, 32'h2);
        memWrite = 1'b0;
        rd_chk("rw_neighbor", 32'h24, 32'h0);

        wr(32'h3FC, 32'h5A5A_0F0F);
        rd_chk("top_word", 32'h3FC, 32'h5A5A_0F0F);

        // reset mid-cycle clears at once and blocks a write held across the edge
        wr(32'h10, 32'hDEAD_BEEF);
        rd_chk("pre_rst", 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", readData, 32'h0);
        memWrite  = 1'b1;
        writeData = 32'h0000_0055;
        @(posedge clk);
        #1;
        memWrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_clr_10", 32'h10, 32'h0);
        rd_chk("rst_clr_8", 32'h8, 32'h0);
        rd_chk("rst_clr_3fc", 32'h3FC, 32'h0);

`ifdef DMEM_BOUNDS_CHECK_EN
        @(negedge clk);
        memRead   = 1'b1;
        memWrite  = 1'b1;
        address   = 32'h400;
        writeData = 32'hAA;
        #1;
        chk("bnd_err", {31'h0, addrErr}, 32'h1);
        chk("bnd_rdata", readData, 32'h0);
        @(posedge clk);
        #1;
        memWrite = 1'b0;
        rd_chk("bnd_no_wrap", 32'h0, 32'h0);
        chk("bnd_err_clr", {31'h0, addrErr}, 32'h0);
`else
        wr(32'h400, 32'hAA);
        rd_chk("wrap_0", 32'h0, 32'hAA);
        rd_chk("wrap_alias", 32'h8000_0400, 32'hAA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised data memory for the single-cycle CPU datapath.
- Sits after the main ALU: the ALU result is the byte address, register read-data-2 is the store data.
- Load data feeds the write-back mux combinationally in the same cycle.
- Reads are asynchronous; writes are synchronous to the rising clock edge.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte-address width in bits.
- DEPTH, 256, number of words; must be a power of two.

Ports:
- clk  input  1  system clock; writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- address  input  ADDR_W  byte address from the ALU result.
- writeData  input  DATA_W  store data.
- memRead  input  1  load enable.
- memWrite  input  1  store enable.
- readData  output  DATA_W  load data.
- addrErr  output  1  out-of-range flag; present only with DMEM_BOUNDS_CHECK_EN.

Behaviour:
- Word index = address[log2(DEPTH)+1 : 2].
- address[1:0] is ignored; accesses are always word-aligned, with no fault on misalignment.
- Address bits above the index field are ignored (address wraps modulo DEPTH*4), except as stated under Optional Feature.
- Read is purely combinational, with no clock latency:
  - readData = mem[index] while memRead=1.
  - readData = 0 while memRead=0.
- Write: on posedge clk, with rst=0 and memWrite=1, mem[index] <= writeData.
- memWrite=0 leaves memory unchanged.
- Reset (rst=1) clears all DEPTH words to 0 immediately, without waiting for a clock edge.
  - While rst=1, writes are blocked and readData = 0.
  - Memory contents after rst deasserts are all-zero.
- Reset asserted mid-operation aborts any pending write: no partial or late write occurs at the next edge.
- Simultaneous memRead=1 and memWrite=1 at the same index:
  - Before the edge, readData shows the old word.
  - After the edge, readData shows writeData (read-through of the array, no bypass register).
- X or undefined address bits must not corrupt other words; implementations may treat an X index as no write.
- No outputs are registered.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - addrErr port exists.
  - addrErr = 1 combinationally whenever (memRead|memWrite)=1 and any address bit above the index field is nonzero.
  - While addrErr=1, the write is suppressed and readData = 0.
  - addrErr = 0 during reset.
- Undefined:
  - addrErr port is absent.
  - High address bits are ignored and the address wraps modulo DEPTH*4.

Test Plan:
- Reset clears memory:
  - Write 0xDEADBEEF to addr 0x10.
  - Assert rst mid-cycle: readData goes to 0 at once.
  - Deassert rst, then read addr 0x10 with memRead=1 -> readData = 0x00000000.
- Store then load:
  - memWrite=1, address=0x8, writeData=0x12345678, one posedge.
  - Then memRead=1, address=0x8 -> readData = 0x12345678 in the same cycle, with no clock edge needed.
- Alignment:
  - Write 0xCAFEF00D to addr 0x4.
  - Read addrs 0x5, 0x6, 0x7 -> each returns 0xCAFEF00D.
- memRead gating and no-write:
  - memRead=0 with valid data at addr 0x8 -> readData = 0.
  - memWrite=0 with writeData=0xFFFFFFFF at an edge -> addr 0x8 is still 0x12345678.
- Read/write same cycle:
  - addr 0x20 holds 0x1; memRead=1, memWrite=1, writeData=0x2.
  - Before the edge readData = 0x1; after the edge readData = 0x2.
- Wrap / bounds:
  - Write 0xAA to addr 0x400 (DEPTH=256).
  - Without macro -> addr 0x0 reads 0xAA.
  - With DMEM_BOUNDS_CHECK_EN -> addrErr=1, addr 0x0 unchanged (0), readData = 0 during the access.
